// File: rtl/mcp_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALU commands, trap causes and datapath mux selects.
package mcp_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB_RD = 4'd7,
        S_IMMEX    = 4'd8,
        S_ALUWB_RT = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRC2_REG  = 2'b00;
    localparam logic [1:0] SRC2_FOUR = 2'b01;
    localparam logic [1:0] SRC2_IMM  = 2'b10;

    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mcp_mem_wait_timer.sv
// Counts cycles a memory access waits on mem_ready and flags when the wait
// reaches MEM_TIMEOUT without completion.
module mcp_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_active,
    input  logic i_exit,
    input  logic i_mem_ready,
    output logic o_timeout
);

    logic [TMO_W-1:0] r_wait_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wait_cnt <= '0;
        end else if (!i_active || i_exit) begin
            r_wait_cnt <= '0;
        end else if (!i_mem_ready) begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
        end
    end

    // A same-cycle mem_ready always wins over the timeout.
    assign o_timeout = i_active && !i_mem_ready && (r_wait_cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mcp_control_fsm_v2.sv
// Multicycle MIPS control FSM with memory handshake, wait timeout and sticky trap.
// Optional performance counters are built when MCP_PERF_COUNT_EN is defined.
module mcp_control_fsm_v2
    import mcp_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MtoRFSel,
    output logic               RFDSel,
    output logic               IDSel,
    output logic               ALUIn1Sel,
    output logic [1:0]         PCSel,
    output logic [1:0]         ALUIn2Sel,
    output logic               ExtSel,
    output logic               IRWE,
    output logic               MWE,
    output logic               PCWE,
    output logic               DRWE,
    output logic               RFWE,
    output logic               Branch,
    output logic               BranchNE,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               trap,
    output logic [1:0]         trap_cause,
`ifdef MCP_PERF_COUNT_EN
    output logic [31:0]        instr_retired,
    output logic [31:0]        stall_cycles,
`endif
    output logic [3:0]         o_dbg_state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_trap_cause;
    logic       w_timeout;
    logic       w_state_exit;

    assign w_state_exit = (w_next_state != r_state);

    mcp_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_wait_timer (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .i_active    (is_mem_wait(r_state)),
        .i_exit      (w_state_exit),
        .i_mem_ready (mem_ready),
        .o_timeout   (w_timeout)
    );

    // Cause is captured only on the edge into TRAP, then held until reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= S_FETCH;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next_state;
            if (r_state != S_TRAP && w_next_state == S_TRAP)
                r_trap_cause <= (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next_state = S_DECODE;
                else if (w_timeout) w_next_state = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW, OP_ADDI: w_next_state = S_MEMADR;
                    OP_RTYPE:              w_next_state = S_EXEC;
                    OP_ANDI, OP_ORI:       w_next_state = S_IMMEX;
                    OP_BEQ, OP_BNE:        w_next_state = S_BRANCH;
                    OP_J:                  w_next_state = S_JUMP;
                    default:               w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      w_next_state = S_MEMRD;
                else if (opcode == OP_SW) w_next_state = S_MEMWR;
                else                      w_next_state = S_ALUWB_RT;
            end
            S_MEMRD: begin
                if (mem_ready)      w_next_state = S_MEMWB;
                else if (w_timeout) w_next_state = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)      w_next_state = S_FETCH;
                else if (w_timeout) w_next_state = S_TRAP;
            end
            S_EXEC:     w_next_state = S_ALUWB_RD;
            S_IMMEX:    w_next_state = S_ALUWB_RT;
            S_MEMWB, S_ALUWB_RD, S_ALUWB_RT, S_BRANCH, S_JUMP:
                        w_next_state = S_FETCH;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        MtoRFSel  = 1'b0;
        RFDSel    = 1'b0;
        IDSel     = 1'b0;
        ALUIn1Sel = 1'b0;
        PCSel     = PC_ALU;
        ALUIn2Sel = SRC2_REG;
        ExtSel    = 1'b0;
        IRWE      = 1'b0;
        MWE       = 1'b0;
        PCWE      = 1'b0;
        DRWE      = 1'b0;
        RFWE      = 1'b0;
        Branch    = 1'b0;
        BranchNE  = 1'b0;
        ALUOp     = '0;
        trap      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUIn2Sel = SRC2_FOUR;
                IRWE      = mem_ready;
                PCWE      = mem_ready;
            end
            S_DECODE:   ALUIn2Sel = SRC2_IMM;
            S_MEMADR: begin
                ALUIn1Sel = 1'b1;
                ALUIn2Sel = SRC2_IMM;
            end
            S_MEMRD: begin
                IDSel   = 1'b1;
                mem_req = 1'b1;
                DRWE    = mem_ready;
            end
            S_MEMWB: begin
                MtoRFSel = 1'b1;
                RFWE     = 1'b1;
            end
            S_MEMWR: begin
                IDSel   = 1'b1;
                mem_req = 1'b1;
                MWE     = 1'b1;
            end
            S_EXEC: begin
                ALUIn1Sel  = 1'b1;
                ALUOp[2:0] = ALU_FUNCT;
            end
            S_ALUWB_RD: begin
                RFDSel = 1'b1;
                RFWE   = 1'b1;
            end
            S_IMMEX: begin
                ALUIn1Sel  = 1'b1;
                ALUIn2Sel  = SRC2_IMM;
                ExtSel     = 1'b1;
                ALUOp[2:0] = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            S_ALUWB_RT: RFWE = 1'b1;
            S_BRANCH: begin
                ALUIn1Sel  = 1'b1;
                ALUOp[2:0] = ALU_SUB;
                PCSel      = PC_ALUOUT;
                Branch     = (opcode == OP_BEQ);
                BranchNE   = (opcode == OP_BNE);
            end
            S_JUMP: begin
                PCSel = PC_JUMP;
                PCWE  = 1'b1;
            end
            S_TRAP:     trap = 1'b1;
            default:    ;
        endcase
    end

    assign trap_cause  = r_trap_cause;
    assign o_dbg_state = r_state;

`ifdef MCP_PERF_COUNT_EN
    logic [31:0] r_instr_retired;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_instr_retired <= '0;
            r_stall_cycles  <= '0;
        end else begin
            if (r_state != S_FETCH && w_next_state == S_FETCH)
                r_instr_retired <= r_instr_retired + 32'd1;
            if (mem_req && !mem_ready)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign instr_retired = r_instr_retired;
    assign stall_cycles  = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mcp_control_fsm_v2.sv
// Directed bench for mcp_control_fsm_v2 (default build, MEM_TIMEOUT=15):
// instruction flows, memory wait stretching, illegal-opcode trap and timeout.
module tb_mcp_control_fsm_v2;

    localparam logic [3:0] T_FETCH    = 4'd0;
    localparam logic [3:0] T_DECODE   = 4'd1;
    localparam logic [3:0] T_MEMADR   = 4'd2;
    localparam logic [3:0] T_MEMRD    = 4'd3;
    localparam logic [3:0] T_MEMWB    = 4'd4;
    localparam logic [3:0] T_MEMWR    = 4'd5;
    localparam logic [3:0] T_EXEC     = 4'd6;
    localparam logic [3:0] T_ALUWB_RD = 4'd7;
    localparam logic [3:0] T_IMMEX    = 4'd8;
    localparam logic [3:0] T_ALUWB_RT = 4'd9;
    localparam logic [3:0] T_BRANCH   = 4'd10;
    localparam logic [3:0] T_JUMP     = 4'd11;
    localparam logic [3:0] T_TRAP     = 4'd12;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, MtoRFSel, RFDSel, IDSel, ALUIn1Sel;
    logic [1:0] PCSel, ALUIn2Sel;
    logic       ExtSel, IRWE, MWE, PCWE, DRWE, RFWE, Branch, BranchNE;
    logic [2:0] ALUOp;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // Clock and reset
    always #5 CLK = ~CLK;

    mcp_control_fsm_v2 dut (
        .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .IDSel(IDSel),
        .ALUIn1Sel(ALUIn1Sel), .PCSel(PCSel), .ALUIn2Sel(ALUIn2Sel), .ExtSel(ExtSel),
        .IRWE(IRWE), .MWE(MWE), .PCWE(PCWE), .DRWE(DRWE), .RFWE(RFWE),
        .Branch(Branch), .BranchNE(BranchNE), .ALUOp(ALUOp), .trap(trap),
        .trap_cause(trap_cause), .o_dbg_state(dbg_state)
    );

    // Driver tasks
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
    endtask

    // Scoreboard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state_q(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed empty-queue expected state", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {28'd0, dbg_state}, {28'd0, e});
        end
    endtask

    initial begin
        RST_N = 1'b0;
        opcode = 6'b000000;
        mem_ready = 1'b0;
        cyc();
        cyc();

        // Reset outputs (FETCH defaults, mem_ready low)
        chk("rst_state", dbg_state, T_FETCH);
        chk("rst_mem_req", mem_req, 1'b1);
        chk("rst_alu2", ALUIn2Sel, 2'b01);
        chk("rst_irwe", IRWE, 1'b0);
        chk("rst_pcwe", PCWE, 1'b0);
        chk("rst_aluop", ALUOp, 3'd0);
        chk("rst_trap", trap, 1'b0);
        chk("rst_cause", trap_cause, 2'b00);
        RST_N = 1'b1;

        // LW, mem_ready tied high: 5 cycles
        opcode = 6'b100011;
        mem_ready = 1'b1;
        #1;
        chk("lw_irwe", IRWE, 1'b1);
        chk("lw_pcwe", PCWE, 1'b1);
        exp_q.push_back(T_FETCH);
        exp_q.push_back(T_DECODE);
        exp_q.push_back(T_MEMADR);
        exp_q.push_back(T_MEMRD);
        exp_q.push_back(T_MEMWB);
        exp_q.push_back(T_FETCH);
        for (int i = 1; i <= 5; i++) begin
            chk_state_q("lw_state");
            chk("lw_drwe", DRWE, (i == 4));
            chk("lw_rfwe", RFWE, (i == 5));
            chk("lw_mtorf", MtoRFSel, (i == 5));
            if (i == 2) chk("lw_dec_alu2", ALUIn2Sel, 2'b10);
            if (i == 3) chk("lw_adr_alu1", ALUIn1Sel, 1'b1);
            if (i == 4) chk("lw_rd_idsel", IDSel, 1'b1);
            cyc();
        end
        chk_state_q("lw_back");

        // SW with mem_ready low for 3 cycles in MEMWR
        opcode = 6'b101011;
        cyc();
        cyc();
        chk("sw_memadr", dbg_state, T_MEMADR);
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("sw_wait_state", dbg_state, T_MEMWR);
            chk("sw_wait_mwe", MWE, 1'b1);
            chk("sw_wait_req", mem_req, 1'b1);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_done_mwe", MWE, 1'b1);
        chk("sw_done_req", mem_req, 1'b1);
        cyc();
        chk("sw_fetch", dbg_state, T_FETCH);
        chk("sw_trap", trap, 1'b0);

        // ORI
        opcode = 6'b001101;
        cyc();
        cyc();
        chk("ori_state", dbg_state, T_IMMEX);
        chk("ori_ext", ExtSel, 1'b1);
        chk("ori_aluop", ALUOp, 3'd4);
        chk("ori_alu2", ALUIn2Sel, 2'b10);
        cyc();
        chk("ori_wb_state", dbg_state, T_ALUWB_RT);
        chk("ori_wb_rfwe", RFWE, 1'b1);
        chk("ori_wb_rfdsel", RFDSel, 1'b0);
        cyc();
        chk("ori_fetch", dbg_state, T_FETCH);

        // ANDI
        opcode = 6'b001100;
        cyc();
        cyc();
        chk("andi_aluop", ALUOp, 3'd3);
        cyc();
        cyc();

        // R-type
        opcode = 6'b000000;
        cyc();
        cyc();
        chk("r_state", dbg_state, T_EXEC);
        chk("r_aluop", ALUOp, 3'd2);
        chk("r_alu2", ALUIn2Sel, 2'b00);
        cyc();
        chk("r_wb_state", dbg_state, T_ALUWB_RD);
        chk("r_wb_rfdsel", RFDSel, 1'b1);
        chk("r_wb_rfwe", RFWE, 1'b1);
        cyc();

        // ADDI goes MEMADR -> ALUWB_RT
        opcode = 6'b001000;
        cyc();
        cyc();
        chk("addi_memadr", dbg_state, T_MEMADR);
        cyc();
        chk("addi_wb", dbg_state, T_ALUWB_RT);
        cyc();
        chk("addi_fetch", dbg_state, T_FETCH);

        // BNE
        opcode = 6'b000101;
        cyc();
        cyc();
        chk("bne_state", dbg_state, T_BRANCH);
        chk("bne_bne", BranchNE, 1'b1);
        chk("bne_beq", Branch, 1'b0);
        chk("bne_aluop", ALUOp, 3'd1);
        chk("bne_pcsel", PCSel, 2'b01);
        cyc();
        chk("bne_fetch", dbg_state, T_FETCH);

        // BEQ
        opcode = 6'b000100;
        cyc();
        cyc();
        chk("beq_beq", Branch, 1'b1);
        chk("beq_bne", BranchNE, 1'b0);
        cyc();

        // J
        opcode = 6'b000010;
        cyc();
        cyc();
        chk("j_state", dbg_state, T_JUMP);
        chk("j_pcsel", PCSel, 2'b10);
        chk("j_pcwe", PCWE, 1'b1);
        cyc();
        chk("j_fetch", dbg_state, T_FETCH);

        // Illegal opcode: sticky trap for 20 cycles, then reset
        opcode = 6'b111111;
        cyc();
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk("ill_state", dbg_state, T_TRAP);
            chk("ill_trap", trap, 1'b1);
            chk("ill_cause", trap_cause, 2'b01);
            chk("ill_req", mem_req, 1'b0);
            chk("ill_en", {IRWE, MWE, PCWE, DRWE, RFWE}, 5'd0);
            cyc();
        end
        mem_ready = 1'b0;
        do_reset();
        chk("ill_rst_state", dbg_state, T_FETCH);
        chk("ill_rst_trap", trap, 1'b0);
        chk("ill_rst_cause", trap_cause, 2'b00);

        // Fetch timeout: 16th waiting cycle traps
        opcode = 6'b100011;
        for (int i = 1; i <= 15; i++) begin
            chk("tmo_wait_state", dbg_state, T_FETCH);
            chk("tmo_wait_trap", trap, 1'b0);
            cyc();
        end
        chk("tmo_c16_state", dbg_state, T_FETCH);
        cyc();
        chk("tmo_state", dbg_state, T_TRAP);
        chk("tmo_trap", trap, 1'b1);
        chk("tmo_cause", trap_cause, 2'b10);

        // mem_ready arriving on cycle 16 wins over the timeout
        do_reset();
        for (int i = 1; i <= 15; i++) cyc();
        mem_ready = 1'b1;
        #1;
        chk("tmo_win_irwe", IRWE, 1'b1);
        cyc();
        chk("tmo_win_state", dbg_state, T_DECODE);
        chk("tmo_win_trap", trap, 1'b0);
        chk("tmo_win_cause", trap_cause, 2'b00);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp_control_fsm_v2.md
Name: mcp_control_fsm_v2

Overview:
Second-generation multicycle MIPS control unit.
- Extends the base multicycle control FSM with ANDI, ORI and BNE.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a timeout counter.
- Adds a sticky trap state for illegal opcodes and memory timeouts.
- Sits between the instruction register opcode field and the multicycle datapath, driving every mux select and write enable.

Parameters:
ALUOP_W, 3, width of ALUOp. Must be ≥3. Upper bits are zero-padded.
MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before trapping. Range 1..255.
TMO_W, 8, width of the wait counter. Must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  synchronous reset, active-low
opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access in progress
MtoRFSel, RFDSel, IDSel, ALUIn1Sel  out  1 each  same meaning as the base control unit
PCSel, ALUIn2Sel  out  2 each  same encodings as the base control unit
ExtSel  out  1  1 = zero-extend Imm (ANDI/ORI), 0 = sign-extend
IRWE, MWE, PCWE, DRWE, RFWE  out  1 each  write enables
Branch, BranchNE  out  1 each  branch-on-zero / branch-on-not-zero
ALUOp  out  ALUOP_W  ALU decoder command: 0 add, 1 sub, 2 funct, 3 and, 4 or
trap  out  1  sticky error flag
trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none

Behaviour:
- State register is updated on posedge CLK. RST_N=0 at a clock edge forces state FETCH, wait_cnt=0, trap_cause=00.
- Outputs are a combinational function of state and mem_ready. Every output has a default of 0 in every state, so there are no latches and no Z values.
- Reset values: all outputs 0, except mem_req=1 and ALUIn2Sel=01 (FETCH defaults).
- FETCH:
  - Drives IDSel=0, ALUIn1Sel=0, ALUIn2Sel=01, ALUOp=0, PCSel=00, mem_req=1.
  - IRWE=PCWE=1 only in the cycle mem_ready=1; the FSM then moves to DECODE.
- DECODE: ALUIn2Sel=10, ALUOp=0 (BTA precompute). Next state by opcode:
  - LW, SW, ADDI → MEMADR
  - R-type → EXEC
  - ANDI, ORI → IMMEX
  - BEQ, BNE → BRANCH
  - J → JUMP
  - any other opcode → TRAP, cause 01
- MEMADR: ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=0. Next: LW → MEMRD, SW → MEMWR, ADDI → ALUWB_RT.
- MEMRD: IDSel=1, mem_req=1. DRWE=1 only when mem_ready=1; then → MEMWB.
- MEMWB: RFDSel=0, MtoRFSel=1, RFWE=1 → FETCH.
- MEMWR: IDSel=1, mem_req=1, MWE=1. On mem_ready → FETCH.
- EXEC: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=2 → ALUWB_RD.
- ALUWB_RD: MtoRFSel=0, RFDSel=1, RFWE=1 → FETCH.
- IMMEX: ALUIn1Sel=1, ALUIn2Sel=10, ExtSel=1, ALUOp=3 (ANDI) or 4 (ORI) → ALUWB_RT.
- ALUWB_RT: MtoRFSel=0, RFDSel=0, RFWE=1 → FETCH.
- BRANCH: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=1, PCSel=01. Branch=1 for BEQ; BranchNE=1 for BNE. → FETCH.
- JUMP: PCSel=10, PCWE=1 → FETCH.
- TRAP:
  - All enables and mem_req are 0; trap=1.
  - trap_cause is held.
  - The FSM stays in TRAP until RST_N=0.
- Wait counter (FETCH, MEMRD, MEMWR):
  - wait_cnt increments each cycle with mem_ready=0 and clears on state exit.
  - If wait_cnt==MEM_TIMEOUT and mem_ready=0 → TRAP, cause 10.
  - mem_ready=1 in that same cycle wins: normal completion, no trap.
- The opcode must be stable from DECODE until FETCH, because it is used in DECODE and MEMADR.
- Reset mid-instruction aborts immediately; partial multi-cycle writes are not completed.
- Base latencies with mem_ready tied high (cycles):
  - LW 5
  - SW 4
  - R-type, ADDI, ANDI, ORI 4
  - BEQ, BNE, J 3

Optional Feature:
MCP_PERF_COUNT_EN
- When defined, adds two outputs:
  - instr_retired[31:0]: increments on every transition into FETCH from a non-FETCH state.
  - stall_cycles[31:0]: increments on every cycle with mem_req=1 and mem_ready=0.
  - Both are cleared by reset and wrap modulo 2^32.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package mcp_ctrl_pkg holds:
  - opcode localparams
  - state encoding (4-bit, 13 states)
  - ALUOp codes
  - trap cause codes
  - PCSel/ALUIn2Sel encodings
- One sub-module, mcp_mem_wait_timer, holds the wait counter and compare and outputs timeout.

Test Plan:
- mem_ready tied 1, opcode=100011 (LW) → states FETCH,DECODE,MEMADR,MEMRD,MEMWB; DRWE=1 in cycle 4; RFWE=1 with MtoRFSel=1 in cycle 5.
- SW with mem_ready low 3 cycles in MEMWR → MWE=1 and mem_req=1 for 4 cycles; then FETCH; trap=0.
- opcode=001101 (ORI) → IMMEX drives ExtSel=1, ALUOp=4; ALUWB_RT drives RFWE=1, RFDSel=0.
- opcode=000101 (BNE) → BRANCH cycle drives BranchNE=1, Branch=0, ALUOp=1, PCSel=01.
- opcode=111111 → after DECODE, trap=1, trap_cause=01, all enables 0 for 20 cycles; RST_N=0 for one edge → FETCH, trap=0.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → trap_cause=10 after 16 cycles; repeat with mem_ready=1 on cycle 16 → DECODE, no trap.
